// File: rtl/divider_eca_pkg.sv
// Shared types and constants for the approximate-arithmetic iterative divider.
// Holds the FSM encoding, default widths and the divide-by-zero quotient fill.
package divider_eca_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_SKIP_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // All-ones fill; users truncate to their own WIDTH (matches RISC-V DIVU by zero).
  localparam logic [63:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/divider_eca_if.sv
// Start/valid handshake bundle between the execute stage and the divider.
// The master issues requests; the slave (divider) returns results.
interface divider_eca_if
  import divider_eca_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SKIP_W = DEF_SKIP_W
);

  logic              Start;
  logic [WIDTH-1:0]  Dividend;
  logic [WIDTH-1:0]  Divisor;
  logic [SKIP_W-1:0] Skip;
  logic              Busy;
  logic              Valid;
  logic [WIDTH-1:0]  Quotient;
  logic [WIDTH-1:0]  Remainder;

  modport master (
    output Start, Dividend, Divisor, Skip,
    input  Busy, Valid, Quotient, Remainder
  );

  modport slave (
    input  Start, Dividend, Divisor, Skip,
    output Busy, Valid, Quotient, Remainder
  );

endinterface

// File: rtl/divider_eca_div_step.sv
// One restoring-division step: compare the (WIDTH+1)-bit trial against the
// divisor and return the next partial remainder plus the quotient bit.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   trial,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] p_next,
  output logic             q
);

  logic [WIDTH:0] divisor_ext;

  always_comb begin
    divisor_ext = {1'b0, divisor};
    q           = (trial >= divisor_ext);
    // When q is set the difference is below the divisor, so WIDTH bits suffice.
    p_next      = q ? WIDTH'(trial - divisor_ext) : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/divider_eca.sv
// Iterative unsigned restoring divider, one quotient bit per cycle MSB first,
// with a run-time Skip that stops early and zeroes the low quotient bits.
module divider_eca
  import divider_eca_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SKIP_W = DEF_SKIP_W
) (
  input logic         clk,
  input logic         reset,
  divider_eca_if.slave bus
);

  localparam logic [SKIP_W:0] WIDTH_C  = (SKIP_W+1)'(WIDTH);
  localparam logic [SKIP_W:0] MAX_SKIP = (SKIP_W+1)'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] dvd_reg, dvd_next;
  logic [WIDTH-1:0] dsr_reg, dsr_next;
  logic [WIDTH-1:0] p_reg, p_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [SKIP_W:0]  skip_reg, skip_next;
  logic [SKIP_W:0]  cnt_reg, cnt_next;
  logic [WIDTH-1:0] quotient_reg, quotient_next;
  logic [WIDTH-1:0] remainder_reg, remainder_next;

  logic [SKIP_W:0]  skip_in;
  logic [SKIP_W:0]  skip_clamped;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] step_p;
  logic             step_q;
  logic [WIDTH-1:0] q_word;

  assign skip_in      = {1'b0, bus.Skip};
  assign skip_clamped = (skip_in > MAX_SKIP) ? MAX_SKIP : skip_in;
  assign trial        = {p_reg, dvd_reg[WIDTH-1]};
  assign q_word       = {q_reg[WIDTH-2:0], step_q};

  div_step #(.WIDTH(WIDTH)) u_step (
    .trial   (trial),
    .divisor (dsr_reg),
    .p_next  (step_p),
    .q       (step_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      dvd_reg       <= '0;
      dsr_reg       <= '0;
      p_reg         <= '0;
      q_reg         <= '0;
      skip_reg      <= '0;
      cnt_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      state_reg     <= state_next;
      dvd_reg       <= dvd_next;
      dsr_reg       <= dsr_next;
      p_reg         <= p_next;
      q_reg         <= q_next;
      skip_reg      <= skip_next;
      cnt_reg       <= cnt_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    dvd_next       = dvd_reg;
    dsr_next       = dsr_reg;
    p_next         = p_reg;
    q_next         = q_reg;
    skip_next      = skip_reg;
    cnt_next       = cnt_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;

    unique case (state_reg)
      IDLE: begin
        if (bus.Start) begin
          dvd_next  = bus.Dividend;
          dsr_next  = bus.Divisor;
          skip_next = skip_clamped;
          cnt_next  = WIDTH_C - skip_clamped;
          p_next    = '0;
          q_next    = '0;
          if (bus.Divisor == '0) begin
            quotient_next  = WIDTH'(DIV0_QUOTIENT);
            remainder_next = bus.Dividend;
            state_next     = DONE;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        p_next   = step_p;
        q_next   = q_word;
        dvd_next = dvd_reg << 1;
        cnt_next = cnt_reg - 1'b1;
        // Last iteration: the skipped LSB positions are filled with zeros.
        if (cnt_reg == (SKIP_W+1)'(1)) begin
          quotient_next  = q_word << skip_reg;
          remainder_next = step_p;
          state_next     = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.Busy      = (state_reg != IDLE);
  assign bus.Valid     = (state_reg == DONE);
  assign bus.Quotient  = quotient_reg;
  assign bus.Remainder = remainder_reg;

endmodule

// File: tb/tb_divider_eca.sv
// Directed bench for divider_eca: exact and truncated division, divide by zero,
// Start while busy, reset mid-run, and Skip clamping on a narrower instance.
module tb_divider_eca;
  import divider_eca_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   cyc;

  divider_eca_if #(.WIDTH(8), .SKIP_W(3)) dif ();
  divider_eca_if #(.WIDTH(6), .SKIP_W(3)) nif ();

  divider_eca #(.WIDTH(8), .SKIP_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  divider_eca #(.WIDTH(6), .SKIP_W(3)) dut_narrow (
    .clk   (clk),
    .reset (reset),
    .bus   (nif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Issues a request; returns sampled in cycle 1 (the cycle after acceptance).
  task automatic start_op(input logic [7:0] dvd, input logic [7:0] dsr, input logic [2:0] skp);
    @(negedge clk);
    dif.Dividend = dvd;
    dif.Divisor  = dsr;
    dif.Skip     = skp;
    dif.Start    = 1'b1;
    @(posedge clk);
    #1;
    dif.Start = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_valid(input string tag, input int exp_cyc, input int exp_q, input int exp_r);
    while (!dif.Valid && cyc < 30) step();
    $display("op %s: valid at cycle %0d Q=%0d R=%0d", tag, cyc, dif.Quotient, dif.Remainder);
    check_eq({tag, "_lat"}, cyc, exp_cyc);
    check_eq({tag, "_q"}, 32'(dif.Quotient), exp_q);
    check_eq({tag, "_r"}, 32'(dif.Remainder), exp_r);
    check_eq({tag, "_busy_done"}, 32'(dif.Busy), 1);
    step();
    check_eq({tag, "_valid_pulse"}, 32'(dif.Valid), 0);
    check_eq({tag, "_idle"}, 32'(dif.Busy), 0);
    check_eq({tag, "_q_hold"}, 32'(dif.Quotient), exp_q);
  endtask

  initial begin
    int valid_seen;
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    reset = 1'b1;
    dif.Start = 1'b0; dif.Dividend = '0; dif.Divisor = '0; dif.Skip = '0;
    nif.Start = 1'b0; nif.Dividend = '0; nif.Divisor = '0; nif.Skip = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check_eq("rst_busy", 32'(dif.Busy), 0);
    check_eq("rst_valid", 32'(dif.Valid), 0);
    check_eq("rst_q", 32'(dif.Quotient), 0);
    check_eq("rst_r", 32'(dif.Remainder), 0);

    start_op(8'd203, 8'd7, 3'd0);
    check_eq("exact_busy_c1", 32'(dif.Busy), 1);
    wait_valid("203div7", 9, 29, 0);

    start_op(8'd200, 8'd7, 3'd0);
    wait_valid("200div7", 9, 28, 4);

    start_op(8'd203, 8'd7, 3'd2);
    wait_valid("203div7_skip2", 7, 28, 1);

    start_op(8'd255, 8'd1, 3'd7);
    wait_valid("255div1_skip7", 2, 128, 0);

    start_op(8'd123, 8'd0, 3'd3);
    wait_valid("123div0", 1, 255, 123);

    // Second request arrives while busy and must be dropped.
    start_op(8'd203, 8'd7, 3'd0);
    while (cyc < 3) step();
    @(negedge clk);
    dif.Dividend = 8'd50; dif.Divisor = 8'd5; dif.Skip = 3'd0; dif.Start = 1'b1;
    step();
    dif.Start = 1'b0;
    wait_valid("busy_ignored", 9, 29, 0);
    check_eq("fresh_cycle", cyc, 10);
    start_op(8'd50, 8'd5, 3'd0);
    wait_valid("50div5", 9, 10, 0);

    // Reset during RUN aborts with no Valid pulse.
    start_op(8'd203, 8'd7, 3'd0);
    while (cyc < 4) step();
    @(negedge clk);
    reset = 1'b1;
    step();
    reset = 1'b0;
    $display("op reset_mid_run: cycle %0d busy=%0d Q=%0d R=%0d", cyc, dif.Busy, dif.Quotient, dif.Remainder);
    check_eq("rstrun_busy", 32'(dif.Busy), 0);
    check_eq("rstrun_valid", 32'(dif.Valid), 0);
    check_eq("rstrun_q", 32'(dif.Quotient), 0);
    check_eq("rstrun_r", 32'(dif.Remainder), 0);
    valid_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (dif.Valid) valid_seen++;
    end
    check_eq("rstrun_no_valid", valid_seen, 0);
    start_op(8'd100, 8'd9, 3'd0);
    wait_valid("100div9", 9, 11, 1);

    // WIDTH=6: Skip=7 clamps to 5, so one iteration and Q = 1<<5.
    @(negedge clk);
    nif.Dividend = 6'd63; nif.Divisor = 6'd1; nif.Skip = 3'd7; nif.Start = 1'b1;
    @(posedge clk);
    #1;
    nif.Start = 1'b0;
    cyc = 1;
    while (!nif.Valid && cyc < 30) step();
    $display("op clamp_w6: valid at cycle %0d Q=%0d R=%0d", cyc, nif.Quotient, nif.Remainder);
    check_eq("clamp_lat", cyc, 2);
    check_eq("clamp_q", 32'(nif.Quotient), 32);
    check_eq("clamp_r", 32'(nif.Remainder), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
